// File: rtl/dump_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dump_ctrl_pkg                                                         |
// | State encoding and counter widths shared by the dump window control.  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package dump_ctrl_pkg;

  localparam int c_FRAME_W = 32;
  localparam int c_HOLD_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_DUMP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/dump_edge.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dump_edge                                                             |
// | Falling-edge detector against a one-cycle-delayed copy of the input.  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module dump_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_fall
);

  logic r_dly;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dly <= 1'b0;
    end else begin
      r_dly <= i_sig;
    end
  end

  assign o_fall = r_dly & ~i_sig;

endmodule
`default_nettype wire

// File: rtl/dump_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dump_ctrl                                                             |
// | Opens a dump window on a frame match or ROM download end, for LEN     |
// | frames (0 = unlimited), and counts frames since reset.                |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module dump_ctrl
  import dump_ctrl_pkg::*;
#(
  parameter bit                   LOADROM     = 1'b0,
  parameter logic [c_FRAME_W-1:0] START_FRAME = 32'd0,
  parameter logic [c_FRAME_W-1:0] LEN         = 32'd0,
  parameter logic [c_HOLD_W-1:0]  HOLDOFF     = 16'd2000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vs,
  input  logic                 dwnld,
  output logic [c_FRAME_W-1:0] frame_cnt,
  output logic                 dump_on,
  output logic                 dump_start,
  output logic                 dump_stop,
  output logic [1:0]           st
);

  logic                 w_vs_fall;
  logic                 w_dl_fall;
  logic                 w_ready;
  state_t               r_state;
  state_t               w_next;
  logic [c_FRAME_W-1:0] r_frame_cnt;
  logic [c_FRAME_W-1:0] r_len;
  logic [c_HOLD_W-1:0]  r_hold;
  logic                 r_start;
  logic                 r_stop;

  dump_edge u_vs_edge (
    .clk    (clk),
    .rst    (rst),
    .i_sig  (vs),
    .o_fall (w_vs_fall)
  );

  dump_edge u_dl_edge (
    .clk    (clk),
    .rst    (rst),
    .i_sig  (dwnld),
    .o_fall (w_dl_fall)
  );

  assign w_ready = (r_hold == HOLDOFF);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (LOADROM) begin
          if (w_dl_fall && w_ready) begin
            w_next = ST_DUMP;
          end
        end else if (START_FRAME == '0) begin
          w_next = ST_DUMP;
        end else begin
          w_next = ST_ARM;
        end
      end
      ST_ARM: begin
        if (w_vs_fall && (r_frame_cnt == START_FRAME)) begin
          w_next = ST_DUMP;
        end
      end
      ST_DUMP: begin
        // the edge being counted now is the one that completes LEN
        if (w_vs_fall && (LEN != '0) && ((r_len + 32'd1) == LEN)) begin
          w_next = ST_DONE;
        end
      end
      default: w_next = ST_DONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_frame_cnt <= '0;
      r_hold      <= '0;
      r_len       <= '0;
      r_start     <= 1'b0;
      r_stop      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_vs_fall) begin
        r_frame_cnt <= r_frame_cnt + 32'd1;
      end
      if (!w_ready) begin
        r_hold <= r_hold + 16'd1;
      end
      if (r_state != ST_DUMP) begin
        r_len <= '0;
      end else if (w_vs_fall) begin
        r_len <= r_len + 32'd1;
      end
      r_start <= (w_next == ST_DUMP) && (r_state != ST_DUMP);
      r_stop  <= (w_next == ST_DONE) && (r_state != ST_DONE);
    end
  end

  assign frame_cnt  = r_frame_cnt;
  assign dump_on    = (r_state == ST_DUMP);
  assign dump_start = r_start;
  assign dump_stop  = r_stop;
  assign st         = r_state;

endmodule
`default_nettype wire

// File: tb/tb_dump_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_dump_ctrl                                                          |
// | Three parameterisations driven with random vs/dwnld pulses; expected  |
// | events are time-stamped into a queue and retired by a monitor.        |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_dump_ctrl;

  localparam int C1_SF   = 5;
  localparam int C1_LEN  = 3;
  localparam int C2_HOLD = 100;
  localparam int C2_LEN  = 2;

  typedef enum int {EV_FRAME, EV_START, EV_STOP, EV_RESET} ev_k_t;
  typedef struct {
    int          inst;
    ev_k_t       kind;
    int unsigned cyc;
    logic [31:0] fc;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst   [3] = '{default: 1'b1};
  logic        vs    [3] = '{default: 1'b1};
  logic        dwnld [3] = '{default: 1'b1};
  logic [31:0] fc    [3];
  logic        on    [3];
  logic        ds    [3];
  logic        dp    [3];
  logic [1:0]  st    [3];

  int unsigned cyc    = 0;
  int          checks = 0;
  int          errors = 0;

  ev_t         evq [$];
  ev_t         keep_q [$];
  int          mk;
  logic [31:0] exp_fc   [3] = '{default: 32'd0};
  bit          exp_on   [3] = '{default: 1'b0};
  bit          exp_done [3] = '{default: 1'b0};
  bit          exp_ds   [3] = '{default: 1'b0};
  bit          exp_dp   [3] = '{default: 1'b0};

  // reference model: counts of edges since reset, plus a dump phase for the ROM case
  logic [31:0] m_fc  [3] = '{default: 32'd0};
  int          m_nv  [3] = '{default: 0};
  int          m_ph  [3] = '{default: 0};
  int          m_len [3] = '{default: 0};
  int unsigned m_rel [3] = '{default: 0};

  dump_ctrl #(.LOADROM(1'b0), .START_FRAME(32'd0), .LEN(32'd0), .HOLDOFF(16'd2000)) u_dut0 (
    .clk(clk), .rst(rst[0]), .vs(vs[0]), .dwnld(dwnld[0]), .frame_cnt(fc[0]),
    .dump_on(on[0]), .dump_start(ds[0]), .dump_stop(dp[0]), .st(st[0]));

  dump_ctrl #(.LOADROM(1'b0), .START_FRAME(32'd5), .LEN(32'd3), .HOLDOFF(16'd10)) u_dut1 (
    .clk(clk), .rst(rst[1]), .vs(vs[1]), .dwnld(dwnld[1]), .frame_cnt(fc[1]),
    .dump_on(on[1]), .dump_start(ds[1]), .dump_stop(dp[1]), .st(st[1]));

  dump_ctrl #(.LOADROM(1'b1), .START_FRAME(32'd0), .LEN(32'd2), .HOLDOFF(16'd100)) u_dut2 (
    .clk(clk), .rst(rst[2]), .vs(vs[2]), .dwnld(dwnld[2]), .frame_cnt(fc[2]),
    .dump_on(on[2]), .dump_start(ds[2]), .dump_stop(dp[2]), .st(st[2]));

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc%0d got=%0h exp=%0h", nm, i, cyc, act, exp);
    end
  endtask

  task automatic push(input int i, input ev_k_t k, input int unsigned c, input logic [31:0] v);
    ev_t e;
    e.inst = i; e.kind = k; e.cyc = c; e.fc = v;
    evq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (cyc >= 1) begin
      for (int i = 0; i < 3; i++) begin
        exp_ds[i] = 1'b0;
        exp_dp[i] = 1'b0;
      end
      keep_q.delete();
      foreach (evq[j]) begin
        mk = evq[j].inst;
        if (evq[j].cyc == cyc) begin
          case (evq[j].kind)
            EV_FRAME: exp_fc[mk] = evq[j].fc;
            EV_START: begin exp_ds[mk] = 1'b1; exp_on[mk] = 1'b1; end
            EV_STOP:  begin exp_dp[mk] = 1'b1; exp_on[mk] = 1'b0; exp_done[mk] = 1'b1; end
            default:  begin exp_fc[mk] = 32'd0; exp_on[mk] = 1'b0; exp_done[mk] = 1'b0; end
          endcase
        end else if (evq[j].cyc < cyc) begin
          chk("stale_event", mk, evq[j].cyc, cyc);
        end else begin
          keep_q.push_back(evq[j]);
        end
      end
      evq = keep_q;
      for (int i = 0; i < 3; i++) begin
        chk("frame_cnt",  i, fc[i], exp_fc[i]);
        chk("dump_on",    i, 32'(on[i]), 32'(exp_on[i]));
        chk("dump_start", i, 32'(ds[i]), 32'(exp_ds[i]));
        chk("dump_stop",  i, 32'(dp[i]), 32'(exp_dp[i]));
        chk("st_is_dump", i, 32'(st[i] == 2'd2), 32'(exp_on[i]));
        chk("st_is_done", i, 32'(st[i] == 2'd3), 32'(exp_done[i]));
      end
    end
  end

  // expected consequences of falls detected at clock edge c
  task automatic model_fall(input int i, input bit v, input bit d, input int unsigned c);
    if (v) begin
      m_fc[i] = m_fc[i] + 32'd1;
      m_nv[i]++;
      push(i, EV_FRAME, c, m_fc[i]);
    end
    if (i == 1 && v) begin
      if (m_nv[1] == C1_SF + 1)          push(1, EV_START, c, 0);
      if (m_nv[1] == C1_SF + 1 + C1_LEN) push(1, EV_STOP, c, 0);
    end
    if (i == 2) begin
      if (m_ph[2] == 0) begin
        if (d && (c - m_rel[2]) > C2_HOLD) begin
          push(2, EV_START, c, 0);
          m_ph[2]  = 1;
          m_len[2] = 0;
        end
      end else if (m_ph[2] == 1 && v) begin
        m_len[2]++;
        if (m_len[2] == C2_LEN) begin
          push(2, EV_STOP, c, 0);
          m_ph[2] = 2;
        end
      end
    end
  endtask

  task automatic pulse(input int i, input bit v, input bit d, input int lo, input int hi);
    @(posedge clk); #1;
    if (v) vs[i] = 1'b0;
    if (d) dwnld[i] = 1'b0;
    model_fall(i, v, d, cyc + 1);
    repeat (lo) @(posedge clk);
    #1;
    if (v) vs[i] = 1'b1;
    if (d) dwnld[i] = 1'b1;
    repeat (hi) @(posedge clk);
  endtask

  task automatic rnd_vs(input int i, input int n);
    repeat (n) pulse(i, 1'b1, 1'b0, $urandom_range(1, 4), $urandom_range(1, 5));
  endtask

  task automatic rel_rst(input int i);
    @(posedge clk); #1;
    rst[i]   = 1'b0;
    m_fc[i]  = 32'd0;
    m_nv[i]  = 0;
    m_ph[i]  = 0;
    m_len[i] = 0;
    m_rel[i] = cyc;
    if (i == 0) push(0, EV_START, cyc + 1, 0);
    repeat (2) @(posedge clk);
  endtask

  task automatic do_reset(input int i, input int n);
    @(posedge clk); #1;
    rst[i] = 1'b1;
    push(i, EV_RESET, cyc + 1, 0);
    repeat (n) @(posedge clk);
    rel_rst(i);
  endtask

  task automatic drive0();
    repeat (3) @(posedge clk);
    rel_rst(0);
    rnd_vs(0, 6);
    @(posedge clk); #1;
    force u_dut0.r_frame_cnt = 32'hFFFF_FFFF;
    m_fc[0] = 32'hFFFF_FFFF;
    push(0, EV_FRAME, cyc, m_fc[0]);
    @(posedge clk); #1;
    release u_dut0.r_frame_cnt;
    rnd_vs(0, 3);
    do_reset(0, 2);
    rnd_vs(0, 4);
  endtask

  task automatic drive1();
    repeat (3) @(posedge clk);
    rel_rst(1);
    rnd_vs(1, 10 + $urandom_range(0, 3));
    do_reset(1, 3);
    rnd_vs(1, $urandom_range(5, 12));
  endtask

  task automatic drive2();
    repeat (3) @(posedge clk);
    rel_rst(2);
    while (cyc < m_rel[2] + 48) @(posedge clk);
    pulse(2, 1'b0, 1'b1, 10, 2);
    rnd_vs(2, $urandom_range(3, 8));
    while (cyc < m_rel[2] + 298) @(posedge clk);
    pulse(2, 1'b1, 1'b1, 3, 3);
    pulse(2, 1'b0, 1'b1, 2, 2);
    rnd_vs(2, C2_LEN);
    pulse(2, 1'b1, 1'b1, 2, 3);
    rnd_vs(2, 2);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) push(i, EV_RESET, 1, 0);
    fork
      drive0();
      drive1();
      drive2();
    join
    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", 0, evq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dump_ctrl.md
DUMP_CTRL -- requirements
Module: dump_ctrl

Interface
REQ-001 Parameter LOADROM, default 0, 1 = dump armed by end of ROM download instead of frame match.
REQ-002 Parameter START_FRAME, default 32'd0, frame_cnt value whose VS falling edge starts dumping.
REQ-003 Parameter LEN, default 32'd0, number of frames to dump; 0 = unlimited.
REQ-004 Parameter HOLDOFF, default 16'd2000, clk cycles after reset during which download end is ignored.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 vs  in  1  vertical sync, synchronous to clk.
REQ-008 dwnld  in  1  ROM download busy (high while downloading).
REQ-009 frame_cnt  out  32  frames elapsed since reset.
REQ-010 dump_on  out  1  dump window active.
REQ-011 dump_start  out  1  one-cycle pulse on window open.
REQ-012 dump_stop  out  1  one-cycle pulse on window close.
REQ-013 st  out  2  current state encoding.

Function
REQ-014 Falling edges of vs and dwnld SHALL be detected against a one-cycle-delayed register of each; delayed registers reset to 0.
REQ-015 frame_cnt SHALL increment by 1 on the cycle after each vs falling edge, in every state, wrapping 0xFFFFFFFF -> 0.
REQ-016 Holdoff counter SHALL count cycles from reset, saturating at HOLDOFF; ready = (count == HOLDOFF).
REQ-017 States SHALL be IDLE=0, ARM=1, DUMP=2, DONE=3; st reflects the registered state.
REQ-018 IDLE, LOADROM=1: dwnld falling edge with ready -> DUMP; edge without ready ignored, stay IDLE.
REQ-019 IDLE, LOADROM=0: START_FRAME==0 -> DUMP next cycle; otherwise -> ARM next cycle.
REQ-020 ARM: vs falling edge while frame_cnt (pre-increment) == START_FRAME -> DUMP; otherwise hold.
REQ-021 DUMP: frame-length counter (reset to 0 on entry) increments per vs falling edge; when LEN!=0 and count reaches LEN -> DONE; LEN==0 stays in DUMP.
REQ-022 DONE: terminal until rst; dwnld and vs edges ignored except for frame_cnt.
REQ-023 dump_on SHALL be 1 exactly while st==DUMP.
REQ-024 dump_start SHALL be 1 only on the first cycle of DUMP; dump_stop only on the first cycle of DONE.
REQ-025 Simultaneous vs and dwnld falling edges in IDLE: dwnld transition taken, frame_cnt still increments.
REQ-026 dwnld rising during DUMP SHALL not affect the window.

Reset
REQ-027 On rst: st=IDLE, frame_cnt=0, dump_on=0, dump_start=0, dump_stop=0, holdoff and length counters 0, effective next cycle.
REQ-028 rst asserted during DUMP SHALL close the window without a dump_stop pulse.

Structure
REQ-029 Package dump_ctrl_pkg SHALL hold the state enum and counter-width constants (32-bit frame, 16-bit holdoff).
REQ-030 One sub-module, dump_edge (registered falling-edge detector), SHALL be instantiated for vs and dwnld.

Verification
REQ-031 LOADROM=0, START_FRAME=0: release rst -> st=DUMP and dump_start pulse one cycle later, dump_on stays high.
REQ-032 LOADROM=0, START_FRAME=5, LEN=3: 10 vs pulses -> dump_on rises after 6th vs falling edge (frame_cnt 5->6), falls after 9th, dump_stop pulses once.
REQ-033 LOADROM=1, HOLDOFF=100: dwnld falls at cycle 50 -> no dump; dwnld rises and falls at cycle 300 -> dump_start next cycle.
REQ-034 frame_cnt preloaded near 0xFFFFFFFF by forcing: two vs falling edges -> wraps to 0, then 1.
REQ-035 rst pulsed mid-DUMP -> all outputs 0 next cycle, no dump_stop; sequence restarts from IDLE.
